// File: rtl/rn_rat.sv
// Register alias table for the rename stage: speculative map (sRAT) for lookups,
// architectural map (aRAT) updated at commit, and a registered handshake toward dispatch.
`ifndef NCPU_PRF_AW
`define NCPU_PRF_AW 6
`endif

module rn_rat #(
    parameter int CONFIG_P_ISSUE_WIDTH  = 1,
    parameter int CONFIG_P_COMMIT_WIDTH = 1,
    localparam int IW  = 1 << CONFIG_P_ISSUE_WIDTH,
    localparam int CW  = 1 << CONFIG_P_COMMIT_WIDTH,
    localparam int AW  = `NCPU_PRF_AW,
    localparam int LW  = 5,
    localparam int NLR = 1 << LW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IW-1:0]    id_valid,
    output logic             id_ready,
    input  logic [IW*LW-1:0] id_lrs1,
    input  logic [IW*LW-1:0] id_lrs2,
    input  logic [IW*LW-1:0] id_lrd,
    input  logic [IW-1:0]    id_lrd_we,
    input  logic [IW*AW-1:0] fl_prd,
    input  logic             fl_stall_req,
    output logic [IW-1:0]    fl_lrd_we,
    output logic [IW-1:0]    fl_pop,
    input  logic             rollback,
    input  logic [CW-1:0]    cmt_fire,
    input  logic [CW-1:0]    cmt_prd_we,
    input  logic [CW*LW-1:0] cmt_lrd,
    input  logic [CW*AW-1:0] cmt_prd,
    output logic [IW-1:0]    rn_valid,
    input  logic             rn_ready,
    output logic [IW*AW-1:0] rn_prs1,
    output logic [IW*AW-1:0] rn_prs2,
    output logic [IW*AW-1:0] rn_prd,
    output logic [IW*AW-1:0] rn_pfree,
    output logic [IW-1:0]    rn_prd_we
);

    generate
        if (IW != 2) begin : g_bad_iw
            $fatal(1, "rn_rat: only an issue width of 2 is supported");
        end
    endgenerate

    logic [AW-1:0]    srat_q [NLR];
    logic [AW-1:0]    arat_q [NLR];

    logic [IW-1:0]    we;
    logic             fire;
    logic [IW*AW-1:0] prs1_d;
    logic [IW*AW-1:0] prs2_d;
    logic [IW*AW-1:0] prd_d;
    logic [IW*AW-1:0] pfree_d;

    // LR0 is pinned to PR0, so a write to it never allocates.
    always_comb begin
        we = '0;
        for (int j = 0; j < IW; j++) begin
            we[j] = id_valid[j] & id_lrd_we[j] & (id_lrd[j*LW +: LW] != '0);
        end
    end

    assign fl_lrd_we = we;
    assign id_ready  = (~|rn_valid | rn_ready) & ~fl_stall_req & ~rollback;
    assign fire      = |id_valid & id_ready;
    assign fl_pop    = we & {IW{fire}};

    // Younger slots see the PRs allocated by older slots of the same group.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        prs1_d  = '0;
        prs2_d  = '0;
        prd_d   = '0;
        pfree_d = '0;
        for (int j = 0; j < IW; j++) begin
            prs1_d[j*AW +: AW]  = srat_q[id_lrs1[j*LW +: LW]];
            prs2_d[j*AW +: AW]  = srat_q[id_lrs2[j*LW +: LW]];
            pfree_d[j*AW +: AW] = srat_q[id_lrd[j*LW +: LW]];
            for (int k = 0; k < j; k++) begin
                if (we[k] && id_lrd[k*LW +: LW] == id_lrs1[j*LW +: LW])
                    prs1_d[j*AW +: AW] = fl_prd[k*AW +: AW];
                if (we[k] && id_lrd[k*LW +: LW] == id_lrs2[j*LW +: LW])
                    prs2_d[j*AW +: AW] = fl_prd[k*AW +: AW];
                if (we[k] && id_lrd[k*LW +: LW] == id_lrd[j*LW +: LW])
                    pfree_d[j*AW +: AW] = fl_prd[k*AW +: AW];
            end
            if (!we[j])
                pfree_d[j*AW +: AW] = '0;
            prd_d[j*AW +: AW] = we[j] ? fl_prd[j*AW +: AW] : '0;
        end
    end

    // Rollback copies the aRAT as registered, so same-cycle commits are not seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: both tables are reset because every LR must map to PR0 out of reset.
            for (int i = 0; i < NLR; i++) begin
                srat_q[i] <= '0;
                arat_q[i] <= '0;
            end
        end else begin
            if (rollback) begin
                for (int i = 0; i < NLR; i++)
                    srat_q[i] <= arat_q[i];
            end else if (fire) begin
                // NOTE: non-blocking writes in slot order; the last one scheduled wins, so the younger slot has priority.
                for (int j = 0; j < IW; j++) begin
                    if (we[j])
                        srat_q[id_lrd[j*LW +: LW]] <= fl_prd[j*AW +: AW];
                end
            end
            for (int j = 0; j < CW; j++) begin
                if (cmt_fire[j] && cmt_prd_we[j] && cmt_lrd[j*LW +: LW] != '0)
                    arat_q[cmt_lrd[j*LW +: LW]] <= cmt_prd[j*AW +: AW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rn_valid  <= '0;
            rn_prs1   <= '0;
            rn_prs2   <= '0;
            rn_prd    <= '0;
            rn_pfree  <= '0;
            rn_prd_we <= '0;
        end else if (rollback) begin
            rn_valid <= '0;
        end else if (fire) begin
            rn_valid  <= id_valid;
            rn_prs1   <= prs1_d;
            rn_prs2   <= prs2_d;
            rn_prd    <= prd_d;
            rn_pfree  <= pfree_d;
            rn_prd_we <= we;
        end else if (rn_ready) begin
            rn_valid <= '0;
        end
    end

endmodule

// File: tb/tb_rn_rat.sv
// Self-checking bench for rn_rat: directed scenarios plus randomized traffic
// checked against a sequential rename/commit reference model.
`timescale 1ns/1ps
`ifndef NCPU_PRF_AW
`define NCPU_PRF_AW 6
`endif

module tb_rn_rat;
    localparam int IW = 2;
    localparam int CW = 2;
    localparam int LW = 5;
    localparam int AW = `NCPU_PRF_AW;

    logic             clk = 1'b0;
    logic             rst;
    logic [IW-1:0]    id_valid;
    logic             id_ready;
    logic [IW*LW-1:0] id_lrs1, id_lrs2, id_lrd;
    logic [IW-1:0]    id_lrd_we;
    logic [IW*AW-1:0] fl_prd;
    logic             fl_stall_req;
    logic [IW-1:0]    fl_lrd_we, fl_pop;
    logic             rollback;
    logic [CW-1:0]    cmt_fire, cmt_prd_we;
    logic [CW*LW-1:0] cmt_lrd;
    logic [CW*AW-1:0] cmt_prd;
    logic [IW-1:0]    rn_valid;
    logic             rn_ready;
    logic [IW*AW-1:0] rn_prs1, rn_prs2, rn_prd, rn_pfree;
    logic [IW-1:0]    rn_prd_we;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [AW-1:0]    m_srat [32];
    logic [AW-1:0]    m_arat [32];
    logic [IW-1:0]    m_valid, m_prd_we;
    logic [IW*AW-1:0] m_prs1, m_prs2, m_prd, m_pfree;

    rn_rat #(.CONFIG_P_ISSUE_WIDTH(1), .CONFIG_P_COMMIT_WIDTH(1)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_lrs1(id_lrs1), .id_lrs2(id_lrs2), .id_lrd(id_lrd), .id_lrd_we(id_lrd_we),
        .fl_prd(fl_prd), .fl_stall_req(fl_stall_req),
        .fl_lrd_we(fl_lrd_we), .fl_pop(fl_pop),
        .rollback(rollback),
        .cmt_fire(cmt_fire), .cmt_prd_we(cmt_prd_we), .cmt_lrd(cmt_lrd), .cmt_prd(cmt_prd),
        .rn_valid(rn_valid), .rn_ready(rn_ready),
        .rn_prs1(rn_prs1), .rn_prs2(rn_prs2), .rn_prd(rn_prd), .rn_pfree(rn_pfree),
        .rn_prd_we(rn_prd_we)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] exp_we();
        logic [IW-1:0] w;
        for (int j = 0; j < IW; j++)
            w[j] = id_valid[j] && id_lrd_we[j] && (id_lrd[j*LW +: LW] != 5'd0);
        return w;
    endfunction

    function automatic logic exp_ready();
        return (m_valid == '0 || rn_ready) && !fl_stall_req && !rollback;
    endfunction

    function automatic logic [IW-1:0] exp_pop();
        return (id_valid != '0 && exp_ready()) ? exp_we() : '0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_srat[i] = '0;
            m_arat[i] = '0;
        end
        m_valid = '0; m_prd_we = '0;
        m_prs1 = '0; m_prs2 = '0; m_prd = '0; m_pfree = '0;
    endtask

    // Advance one clock: rename the group one instruction at a time against a
    // working copy of the map, apply commits in slot order, then restore on rollback.
    task automatic tick();
        logic [AW-1:0]    map [32];
        logic [AW-1:0]    arat_old [32];
        logic [IW-1:0]    w;
        logic             fire;
        logic [IW*AW-1:0] n_prs1, n_prs2, n_prd, n_pfree;
        logic [LW-1:0]    d;
        w    = exp_we();
        fire = (id_valid != '0) && exp_ready();
        map  = m_srat;
        arat_old = m_arat;
        n_prs1 = '0; n_prs2 = '0; n_prd = '0; n_pfree = '0;
        for (int j = 0; j < IW; j++) begin
            d = id_lrd[j*LW +: LW];
            n_prs1[j*AW +: AW] = map[id_lrs1[j*LW +: LW]];
            n_prs2[j*AW +: AW] = map[id_lrs2[j*LW +: LW]];
            if (w[j]) begin
                n_pfree[j*AW +: AW] = map[d];
                n_prd[j*AW +: AW]   = fl_prd[j*AW +: AW];
                map[d] = fl_prd[j*AW +: AW];
            end
        end
        for (int j = 0; j < CW; j++)
            if (cmt_fire[j] && cmt_prd_we[j] && cmt_lrd[j*LW +: LW] != 5'd0)
                m_arat[cmt_lrd[j*LW +: LW]] = cmt_prd[j*AW +: AW];
        if (rollback) begin
            m_srat  = arat_old;
            m_valid = '0;
        end else if (fire) begin
            m_srat = map;
            m_valid = id_valid; m_prd_we = w;
            m_prs1 = n_prs1; m_prs2 = n_prs2; m_prd = n_prd; m_pfree = n_pfree;
        end else if (rn_ready) begin
            m_valid = '0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = '0; id_lrs1 = '0; id_lrs2 = '0; id_lrd = '0; id_lrd_we = '0;
        fl_prd = '0; fl_stall_req = 1'b0; rollback = 1'b0; rn_ready = 1'b1;
        cmt_fire = '0; cmt_prd_we = '0; cmt_lrd = '0; cmt_prd = '0;
    endtask

    task automatic drive_group(input logic [1:0] v,
                               input logic [4:0] d0, input logic [4:0] a0, input logic [4:0] b0, input logic e0,
                               input logic [4:0] d1, input logic [4:0] a1, input logic [4:0] b1, input logic e1,
                               input logic [AW-1:0] p0, input logic [AW-1:0] p1);
        id_valid  = v;
        id_lrd    = {d1, d0};
        id_lrs1   = {a1, a0};
        id_lrs2   = {b1, b0};
        id_lrd_we = {e1, e0};
        fl_prd    = {p1, p0};
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        model_clear();
        rst = 1'b0;
        idle_inputs();
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        apply_reset();
        n_tests++; if (rn_valid !== 2'b00) begin n_fail++; $display("FAIL reset_valid got %b want 00", rn_valid); end
        n_tests++; if ({rn_prs1, rn_prs2, rn_prd, rn_pfree, rn_prd_we} !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", {rn_prs1, rn_prs2, rn_prd, rn_pfree}); end
        n_tests++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", id_ready); end
    endtask

    task automatic test_basic();
        drive_group(2'b01, 5'd1, 5'd2, 5'd3, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, AW'(4), AW'(5));
        n_tests++; if (fl_pop !== 2'b01) begin n_fail++; $display("FAIL basic_pop got %b want 01", fl_pop); end
        n_tests++; if (fl_lrd_we !== 2'b01) begin n_fail++; $display("FAIL basic_lrd_we got %b want 01", fl_lrd_we); end
        tick();
        n_tests++; if (rn_valid !== 2'b01) begin n_fail++; $display("FAIL basic_valid got %b want 01", rn_valid); end
        n_tests++; if (rn_prs1[AW-1:0] !== AW'(0) || rn_prs2[AW-1:0] !== AW'(0)) begin n_fail++; $display("FAIL basic_prs got %0d/%0d want 0/0", rn_prs1[AW-1:0], rn_prs2[AW-1:0]); end
        n_tests++; if (rn_prd[AW-1:0] !== AW'(4)) begin n_fail++; $display("FAIL basic_prd got %0d want 4", rn_prd[AW-1:0]); end
        n_tests++; if (rn_pfree[AW-1:0] !== AW'(0)) begin n_fail++; $display("FAIL basic_pfree got %0d want 0", rn_pfree[AW-1:0]); end
    endtask

    task automatic test_bypass();
        drive_group(2'b11, 5'd1, 5'd0, 5'd0, 1'b1, 5'd2, 5'd1, 5'd1, 1'b1, AW'(8), AW'(9));
        tick();
        n_tests++; if (rn_prs1[AW +: AW] !== AW'(8) || rn_prs2[AW +: AW] !== AW'(8)) begin n_fail++; $display("FAIL bypass_src got %0d/%0d want 8/8", rn_prs1[AW +: AW], rn_prs2[AW +: AW]); end
        n_tests++; if (rn_prd[AW +: AW] !== AW'(9)) begin n_fail++; $display("FAIL bypass_prd got %0d want 9", rn_prd[AW +: AW]); end
        n_tests++; if (rn_pfree[AW-1:0] !== AW'(4)) begin n_fail++; $display("FAIL bypass_pfree0 got %0d want 4", rn_pfree[AW-1:0]); end
        drive_group(2'b01, 5'd0, 5'd1, 5'd2, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, AW'(1), AW'(2));
        tick();
        n_tests++; if (rn_prs1[AW-1:0] !== AW'(8) || rn_prs2[AW-1:0] !== AW'(9)) begin n_fail++; $display("FAIL bypass_next got %0d/%0d want 8/9", rn_prs1[AW-1:0], rn_prs2[AW-1:0]); end
    endtask

    task automatic test_same_lrd();
        drive_group(2'b11, 5'd7, 5'd0, 5'd0, 1'b1, 5'd7, 5'd0, 5'd0, 1'b1, AW'(10), AW'(11));
        tick();
        n_tests++; if (rn_pfree !== {AW'(10), AW'(0)}) begin n_fail++; $display("FAIL waw_pfree got %h want %h", rn_pfree, {AW'(10), AW'(0)}); end
        // Read r7 while writing r0 in the same slot
        drive_group(2'b01, 5'd0, 5'd7, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, AW'(12), AW'(13));
        n_tests++; if (fl_lrd_we !== 2'b00) begin n_fail++; $display("FAIL r0_lrd_we got %b want 00", fl_lrd_we); end
        tick();
        n_tests++; if (rn_prs1[AW-1:0] !== AW'(11)) begin n_fail++; $display("FAIL waw_srat got %0d want 11", rn_prs1[AW-1:0]); end
        n_tests++; if (rn_prd[AW-1:0] !== AW'(0) || rn_prd_we !== 2'b00) begin n_fail++; $display("FAIL r0_prd got %0d we %b want 0 we 00", rn_prd[AW-1:0], rn_prd_we); end
    endtask

    task automatic test_backpressure();
        idle_inputs();
        tick();
        rn_ready = 1'b0;
        drive_group(2'b11, 5'd5, 5'd0, 5'd0, 1'b1, 5'd6, 5'd0, 5'd0, 1'b1, AW'(20), AW'(21));
        tick();
        drive_group(2'b01, 5'd5, 5'd6, 5'd5, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, AW'(22), AW'(23));
        for (int c = 0; c < 3; c++) begin
            n_tests++; if (id_ready !== 1'b0 || fl_pop !== 2'b00) begin n_fail++; $display("FAIL bp_stall c%0d got ready %b pop %b want 0 00", c, id_ready, fl_pop); end
            tick();
            n_tests++; if (rn_valid !== 2'b11 || rn_prd !== {AW'(21), AW'(20)} || {rn_prs1, rn_prs2, rn_pfree} !== {m_prs1, m_prs2, m_pfree}) begin n_fail++; $display("FAIL bp_hold c%0d got v %b prd %h want 11 %h", c, rn_valid, rn_prd, {AW'(21), AW'(20)}); end
        end
        rn_ready = 1'b1;
        #1;
        n_tests++; if (id_ready !== 1'b1 || fl_pop !== 2'b01) begin n_fail++; $display("FAIL bp_release got ready %b pop %b want 1 01", id_ready, fl_pop); end
        tick();
        n_tests++; if (rn_prs1[AW-1:0] !== AW'(21) || rn_prs2[AW-1:0] !== AW'(20) || rn_pfree[AW-1:0] !== AW'(20) || rn_prd[AW-1:0] !== AW'(22)) begin n_fail++; $display("FAIL bp_next got %0d %0d %0d %0d want 21 20 20 22", rn_prs1[AW-1:0], rn_prs2[AW-1:0], rn_pfree[AW-1:0], rn_prd[AW-1:0]); end
    endtask

    task automatic test_rollback();
        idle_inputs();
        cmt_fire = 2'b11; cmt_prd_we = 2'b11;
        cmt_lrd = {5'd2, 5'd1}; cmt_prd = {AW'(9), AW'(8)};
        #1;
        tick();
        idle_inputs();
        drive_group(2'b01, 5'd1, 5'd0, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, AW'(20), AW'(0));
        tick();
        n_tests++; if (rn_prd[AW-1:0] !== AW'(20)) begin n_fail++; $display("FAIL rb_spec got %0d want 20", rn_prd[AW-1:0]); end
        rollback = 1'b1;
        #1;
        n_tests++; if (id_ready !== 1'b0 || fl_pop !== 2'b00) begin n_fail++; $display("FAIL rb_nofire got ready %b pop %b want 0 00", id_ready, fl_pop); end
        tick();
        n_tests++; if (rn_valid !== 2'b00) begin n_fail++; $display("FAIL rb_valid got %b want 00", rn_valid); end
        rollback = 1'b0;
        drive_group(2'b11, 5'd0, 5'd1, 5'd2, 1'b0, 5'd0, 5'd7, 5'd5, 1'b0, AW'(0), AW'(0));
        tick();
        n_tests++; if (rn_prs1[AW-1:0] !== AW'(8) || rn_prs2[AW-1:0] !== AW'(9)) begin n_fail++; $display("FAIL rb_restore got %0d/%0d want 8/9", rn_prs1[AW-1:0], rn_prs2[AW-1:0]); end
        n_tests++; if (rn_prs1[AW +: AW] !== AW'(0) || rn_prs2[AW +: AW] !== AW'(0)) begin n_fail++; $display("FAIL rb_uncommitted got %0d/%0d want 0/0", rn_prs1[AW +: AW], rn_prs2[AW +: AW]); end
    endtask

    task automatic test_stall();
        idle_inputs();
        fl_stall_req = 1'b1;
        drive_group(2'b11, 5'd3, 5'd0, 5'd0, 1'b1, 5'd4, 5'd3, 5'd0, 1'b1, AW'(30), AW'(31));
        n_tests++; if (id_ready !== 1'b0 || fl_pop !== 2'b00 || fl_lrd_we !== 2'b11) begin n_fail++; $display("FAIL stall_comb got ready %b pop %b we %b want 0 00 11", id_ready, fl_pop, fl_lrd_we); end
        tick();
        n_tests++; if (rn_valid !== 2'b00) begin n_fail++; $display("FAIL stall_valid got %b want 00", rn_valid); end
        fl_stall_req = 1'b0;
        #1;
        n_tests++; if (fl_pop !== 2'b11) begin n_fail++; $display("FAIL stall_release got pop %b want 11", fl_pop); end
        tick();
        n_tests++; if (rn_valid !== 2'b11 || rn_prd !== {AW'(31), AW'(30)} || rn_prs1[AW +: AW] !== AW'(30) || rn_pfree !== '0) begin n_fail++; $display("FAIL stall_group got v %b prd %h prs1 %h pfree %h", rn_valid, rn_prd, rn_prs1, rn_pfree); end
    endtask

    task automatic test_reset_mid();
        rollback = 1'b1;
        cmt_fire = 2'b01; cmt_prd_we = 2'b01; cmt_lrd = {5'd0, 5'd1}; cmt_prd = {AW'(0), AW'(33)};
        apply_reset();
        drive_group(2'b01, 5'd0, 5'd1, 5'd3, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, AW'(0), AW'(0));
        tick();
        n_tests++; if (rn_prs1[AW-1:0] !== AW'(0) || rn_prs2[AW-1:0] !== AW'(0) || rn_valid !== 2'b01) begin n_fail++; $display("FAIL reset_mid got %0d/%0d v %b want 0/0 01", rn_prs1[AW-1:0], rn_prs2[AW-1:0], rn_valid); end
    endtask

    task automatic test_random();
        logic [1:0] vsel;
        for (int c = 0; c < 800; c++) begin
            vsel = 2'($urandom_range(0, 2));
            id_valid     = (vsel == 2'd0) ? 2'b00 : (vsel == 2'd1) ? 2'b01 : 2'b11;
            id_lrd       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            id_lrs1      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            id_lrs2      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            id_lrd_we    = 2'($urandom_range(0, 3));
            fl_prd       = {AW'($urandom_range(1, 63)), AW'($urandom_range(1, 63))};
            fl_stall_req = ($urandom_range(0, 4) == 0);
            rn_ready     = ($urandom_range(0, 3) != 0);
            rollback     = ($urandom_range(0, 19) == 0);
            cmt_fire     = rollback ? 2'b00 : 2'($urandom_range(0, 3));
            cmt_prd_we   = 2'($urandom_range(0, 3));
            cmt_lrd      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            cmt_prd      = {AW'($urandom_range(1, 63)), AW'($urandom_range(1, 63))};
            #1;
            n_tests++; if ({id_ready, fl_lrd_we, fl_pop} !== {exp_ready(), exp_we(), exp_pop()}) begin n_fail++; $display("FAIL rnd_comb c%0d got %b %b %b want %b %b %b", c, id_ready, fl_lrd_we, fl_pop, exp_ready(), exp_we(), exp_pop()); end
            tick();
            n_tests++; if ({rn_valid, rn_prd_we, rn_prs1, rn_prs2, rn_prd, rn_pfree} !== {m_valid, m_prd_we, m_prs1, m_prs2, m_prd, m_pfree}) begin n_fail++; $display("FAIL rnd_out c%0d got v%b we%b %h %h %h %h want v%b we%b %h %h %h %h", c, rn_valid, rn_prd_we, rn_prs1, rn_prs2, rn_prd, rn_pfree, m_valid, m_prd_we, m_prs1, m_prs2, m_prd, m_pfree); end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_clear();
        test_reset();
        test_basic();
        test_bypass();
        test_same_lrd();
        test_backpressure();
        test_rollback();
        test_stall();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
